// File: rtl/RV32i_pkg.sv
// Shared types and constants for the RV32i data-memory responder.
// Holds the responder FSM state enum and the wait-jitter LFSR taps.
package RV32i_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_resp_state_t;

    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
    localparam logic [7:0] DMEM_RESP_LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] dmem_resp_lfsr_next(
        input logic [7:0] s
    );
        return {s[6:0], ^(s & DMEM_RESP_LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dmem_resp_lfsr.sv
// 8-bit Fibonacci LFSR that supplies wait-state jitter to the responder.
// Ports: i_clk, i_rst_n (async, active-low), i_en (advance), o_lfsr (state).
module dmem_resp_lfsr
    import RV32i_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    output logic [7:0] o_lfsr
);

    logic [7:0] r_lfsr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= SEED;
        end else if (i_en) begin
            r_lfsr <= dmem_resp_lfsr_next(r_lfsr);
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM behind the core's dmem request/valid
// handshake, inserting LATENCY wait cycles before a one-cycle valid pulse.
// Ports: clk_i, resetn_i (async, active-low), dmem_add_i (byte address),
// dmem_di_i, dmem_we_i, dmem_re_i, dmem_ble_i (request side);
// dmem_do_o, dmem_valid_o (response side).
// Build option: define DMEM_RESP_LFSR_EN to add 0..3 cycles of LFSR
// jitter to every accepted request.
module dmem_responder
    import RV32i_pkg::*;
#(
    parameter int         DEPTH_WORDS = 1024,
    parameter int         LATENCY     = 1,
    parameter             INIT_FILE   = "",
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic [31:0] dmem_add_i,
    input  logic [31:0] dmem_di_i,
    input  logic        dmem_we_i,
    input  logic        dmem_re_i,
    input  logic [3:0]  dmem_ble_i,
    output logic [31:0] dmem_do_o,
    output logic        dmem_valid_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // Wide enough for LATENCY plus the maximum jitter of 3.
    localparam int CW = $clog2(LATENCY + 5);

    dmem_resp_state_t r_state;
    logic [CW-1:0]    r_cnt;
    logic [31:0]      r_mem [DEPTH_WORDS];

    logic [AW-1:0]    w_idx;
    logic             w_req;
    logic [CW-1:0]    w_lat;
    logic             w_valid;
    logic             w_unused;

    assign w_idx = dmem_add_i[AW+1:2];
    assign w_req = dmem_we_i | dmem_re_i;

`ifdef DMEM_RESP_LFSR_EN
    logic [7:0] w_lfsr;
    logic       w_adv;

    // One step per request leaving IDLE, including zero-wait hits.
    assign w_adv = resetn_i & w_req & (r_state == IDLE);

    dmem_resp_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_clk   (clk_i),
        .i_rst_n (resetn_i),
        .i_en    (w_adv),
        .o_lfsr  (w_lfsr)
    );

    assign w_lat    = CW'(LATENCY) + CW'(w_lfsr[1:0]);
    assign w_unused = ^{dmem_add_i[31:AW+2], dmem_add_i[1:0], w_lfsr[7:2]};
`else
    assign w_lat    = CW'(LATENCY);
    assign w_unused = ^{dmem_add_i[31:AW+2], dmem_add_i[1:0], LFSR_SEED};
`endif

    // Valid is gated by reset so both outputs drop asynchronously.
    assign w_valid = resetn_i & w_req &
                     ((r_state == RESP) |
                      ((r_state == IDLE) & (w_lat == '0)));

    assign dmem_valid_o = w_valid;
    assign dmem_do_o    = w_valid ? r_mem[w_idx] : 32'h0;

    // The IDLE cycle that sees the request is the first wait cycle, so
    // WAIT holds for L-1 cycles (cnt runs L-2..0) and RESP lands in cycle L.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_req && (w_lat != '0)) begin
                        if (w_lat == CW'(1)) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= w_lat - CW'(2);
                        end
                    end
                end
                WAIT: begin
                    if (!w_req) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == '0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Memory has no reset; writes commit at the edge ending the valid cycle.
    always_ff @(posedge clk_i) begin
        if (w_valid && dmem_we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_ble_i[i]) begin
                    r_mem[w_idx][8*i +: 8] <= dmem_di_i[8*i +: 8];
                end
            end
        end
    end

endmodule
